// File: rtl/rr_stream_arbiter_pkg.sv
// rtl/rr_stream_arbiter_pkg.sv - shared types, limits and winner search for rr_stream_arbiter
package rr_stream_arbiter_pkg;

  localparam int DEFAULT_NUM_SRC = 4;
  localparam int MAX_SRC         = 16;
  localparam int MAX_SRC_W       = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_SRC_W-1:0] idx;
  } pick_t;

  // Requester closest after ptr (wrapping within num_src) wins.
  function automatic pick_t rr_pick(input logic [MAX_SRC-1:0]   req,
                                    input logic [MAX_SRC_W-1:0] ptr,
                                    input int                   num_src);
    pick_t res;
    int    best;
    int    d;
    res  = '0;
    best = MAX_SRC;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (i < num_src && req[i]) begin
        d = i - int'(ptr) - 1;
        if (d < 0) d = d + num_src;
        if (d < best) begin
          best      = d;
          res.found = 1'b1;
          res.idx   = MAX_SRC_W'(i);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_stream_arbiter_pick_core.sv
// rtl/rr_stream_arbiter_pick_core.sv - rotate, priority-encode and rotate back to find the next winner
module rr_pick_core
  import rr_stream_arbiter_pkg::*;
#(
  parameter  int NUM_SRC = DEFAULT_NUM_SRC,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic               found,
  output logic [SRC_W-1:0]   winner
);

  logic [SRC_W:0]       sh;
  logic [MAX_SRC-1:0]   rot;
  pick_t                enc;
  logic [MAX_SRC_W:0]   sum;

  always_comb begin
    sh  = {1'b0, ptr} + (SRC_W+1)'(1);
    // Rotating by ptr+1 puts the highest-priority requester at bit 0.
    rot = MAX_SRC'(NUM_SRC'({req, req} >> sh));
    enc = rr_pick(rot, MAX_SRC_W'(NUM_SRC-1), NUM_SRC);
    sum = {1'b0, enc.idx} + (MAX_SRC_W+1)'(sh);
    if (sum >= (MAX_SRC_W+1)'(NUM_SRC)) sum = sum - (MAX_SRC_W+1)'(NUM_SRC);
    found  = enc.found;
    winner = sum[SRC_W-1:0];
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// rtl/rr_stream_arbiter.sv - packet-granular round-robin merge of NUM_SRC streams into one registered stream
module rr_stream_arbiter
  import rr_stream_arbiter_pkg::*;
#(
  parameter  int NUM_SRC    = DEFAULT_NUM_SRC,
  parameter  int WORD_WIDTH = 8,
  localparam int SRC_W      = $clog2(NUM_SRC)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [NUM_SRC-1:0]                   s_valid,
  output logic [NUM_SRC-1:0]                   s_ready,
  input  logic [NUM_SRC-1:0][WORD_WIDTH-1:0]   s_data,
  input  logic [NUM_SRC-1:0]                   s_last,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [WORD_WIDTH-1:0]                m_data,
  output logic                                 m_last,
  output logic [SRC_W-1:0]                     m_src
);

  arb_state_t            state_q, state_d;
  logic [SRC_W-1:0]      ptr_q, ptr_d;
  logic [SRC_W-1:0]      gnt_q, gnt_d;
  logic                  m_valid_q, m_valid_d;
  logic [WORD_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic [SRC_W-1:0]      m_src_q, m_src_d;

  logic                  pick_found;
  logic [SRC_W-1:0]      pick_idx;
  logic                  can_acc;
  logic                  sel_ok;
  logic                  accept;
  logic [SRC_W-1:0]      sel;

  rr_pick_core #(.NUM_SRC(NUM_SRC)) u_pick (
    .req    (s_valid),
    .ptr    (ptr_q),
    .found  (pick_found),
    .winner (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_src_d   = m_src_q;

    can_acc = m_ready | ~m_valid_q;
    // A locked grant is offered ready even while its source is idle mid-packet.
    sel     = (state_q == LOCKED) ? gnt_q : pick_idx;
    sel_ok  = (state_q == LOCKED) | pick_found;
    s_ready      = '0;
    s_ready[sel] = sel_ok & can_acc;
    accept  = sel_ok & can_acc & s_valid[sel];

    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data[sel];
      m_last_d  = s_last[sel];
      m_src_d   = sel;
      if (s_last[sel]) begin
        state_d = IDLE;
        ptr_d   = sel;
      end else begin
        state_d = LOCKED;
        gnt_d   = sel;
      end
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ptr_q     <= SRC_W'(NUM_SRC-1);
      gnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_src_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_src_q   <= m_src_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_src   = m_src_q;

endmodule
